// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank: R/W control registers plus read-only status inputs,
// with one-cycle write/read strobes. Independent single-outstanding write and read channels.
module axil_reg_bank #(
  parameter int unsigned ADDR_WIDTH = 40,
  parameter int unsigned N_CTRL     = 8,
  parameter int unsigned N_STAT     = 8,
  parameter logic [31:0] CTRL_RESET = 32'h0
) (
  input  logic                     axil_clk,
  input  logic                     axil_rst,
  input  logic [ADDR_WIDTH-1:0]    axil_awaddr,
  input  logic [2:0]               axil_awprot,
  input  logic                     axil_awvalid,
  output logic                     axil_awready,
  input  logic [31:0]              axil_wdata,
  input  logic [3:0]               axil_wstrb,
  input  logic                     axil_wvalid,
  output logic                     axil_wready,
  output logic [1:0]               axil_bresp,
  output logic                     axil_bvalid,
  input  logic                     axil_bready,
  input  logic [ADDR_WIDTH-1:0]    axil_araddr,
  input  logic [2:0]               axil_arprot,
  input  logic                     axil_arvalid,
  output logic                     axil_arready,
  output logic [31:0]              axil_rdata,
  output logic [1:0]               axil_rresp,
  output logic                     axil_rvalid,
  input  logic                     axil_rready,
  output logic [32*N_CTRL-1:0]     ctrl_regs,
  output logic [N_CTRL-1:0]        ctrl_wr_pulse,
  input  logic [32*N_STAT-1:0]     status_regs,
  output logic [N_STAT-1:0]        stat_rd_pulse
);

  localparam int unsigned N_REGS = N_CTRL + N_STAT;
  localparam int unsigned IW     = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [IW:0] CTRL_LIM = (IW+1)'(N_CTRL);
  localparam logic [IW:0] REGS_LIM = (IW+1)'(N_REGS);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic {W_ADDR_DATA, W_RESP} w_state_e;
  typedef enum logic {R_ADDR, R_DATA} r_state_e;

  w_state_e                w_state_q, w_state_n;
  r_state_e                r_state_q, r_state_n;
  logic                    aw_held_q, aw_held_n, w_held_q, w_held_n;
  logic [IW-1:0]           aw_idx_q, aw_idx_n, cw_idx, r_idx;
  logic [31:0]             wdata_q, wdata_n, cw_data;
  logic [3:0]              wstrb_q, wstrb_n, cw_strb;
  logic [N_CTRL-1:0][31:0] ctrl_q, ctrl_n;
  logic                    awready_n, wready_n, bvalid_n, arready_n, rvalid_n;
  logic [1:0]              bresp_n, rresp_n;
  logic [31:0]             rdata_n;
  logic [N_CTRL-1:0]       wr_pulse_n;
  logic [N_STAT-1:0]       rd_pulse_n;
  logic                    aw_hs, w_hs, ar_hs;
  logic                    unused_bits;

  assign aw_hs       = axil_awvalid & axil_awready;
  assign w_hs        = axil_wvalid & axil_wready;
  assign ar_hs       = axil_arvalid & axil_arready;
  assign ctrl_regs   = ctrl_q;
  assign unused_bits = ^{axil_awprot, axil_arprot, axil_awaddr, axil_araddr};

  // Write channel: collect AW and W in either order, commit when both are held.
  always_comb begin
    w_state_n  = w_state_q;
    aw_held_n  = aw_held_q;
    w_held_n   = w_held_q;
    aw_idx_n   = aw_idx_q;
    wdata_n    = wdata_q;
    wstrb_n    = wstrb_q;
    awready_n  = axil_awready;
    wready_n   = axil_wready;
    bvalid_n   = axil_bvalid;
    bresp_n    = axil_bresp;
    ctrl_n     = ctrl_q;
    wr_pulse_n = '0;
    cw_idx     = aw_hs ? axil_awaddr[IW+1:2] : aw_idx_q;
    cw_data    = w_hs ? axil_wdata : wdata_q;
    cw_strb    = w_hs ? axil_wstrb : wstrb_q;
    case (w_state_q)
      W_ADDR_DATA: begin
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          w_state_n = W_RESP;
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
          awready_n = 1'b0;
          wready_n  = 1'b0;
          bvalid_n  = 1'b1;
          if ({1'b0, cw_idx} < CTRL_LIM) begin
            bresp_n = OKAY;
            for (int k = 0; k < int'(N_CTRL); k++) begin
              if (cw_idx == IW'(k)) begin
                wr_pulse_n[k] = 1'b1;
                for (int b = 0; b < 4; b++) begin
                  if (cw_strb[b]) ctrl_n[k][8*b +: 8] = cw_data[8*b +: 8];
                end
              end
            end
          end else begin
            bresp_n = SLVERR;
          end
        end else begin
          if (aw_hs) begin
            aw_held_n = 1'b1;
            aw_idx_n  = axil_awaddr[IW+1:2];
          end
          if (w_hs) begin
            w_held_n = 1'b1;
            wdata_n  = axil_wdata;
            wstrb_n  = axil_wstrb;
          end
          awready_n = !(aw_held_q || aw_hs);
          wready_n  = !(w_held_q || w_hs);
        end
      end
      W_RESP: begin
        if (axil_bvalid && axil_bready) begin
          w_state_n = W_ADDR_DATA;
          bvalid_n  = 1'b0;
          awready_n = 1'b1;
          wready_n  = 1'b1;
        end
      end
      default: w_state_n = W_ADDR_DATA;
    endcase
  end

  // Read channel: reads see the control registers before any same-cycle commit.
  always_comb begin
    r_state_n  = r_state_q;
    arready_n  = axil_arready;
    rvalid_n   = axil_rvalid;
    rresp_n    = axil_rresp;
    rdata_n    = axil_rdata;
    rd_pulse_n = '0;
    r_idx      = axil_araddr[IW+1:2];
    case (r_state_q)
      R_ADDR: begin
        arready_n = 1'b1;
        if (ar_hs) begin
          r_state_n = R_DATA;
          arready_n = 1'b0;
          rvalid_n  = 1'b1;
          rresp_n   = OKAY;
          rdata_n   = '0;
          if ({1'b0, r_idx} < CTRL_LIM) begin
            for (int k = 0; k < int'(N_CTRL); k++) begin
              if (r_idx == IW'(k)) rdata_n = ctrl_q[k];
            end
          end else if ({1'b0, r_idx} < REGS_LIM) begin
            for (int k = 0; k < int'(N_STAT); k++) begin
              if (r_idx == IW'(N_CTRL + k)) begin
                rdata_n       = status_regs[32*k +: 32];
                rd_pulse_n[k] = 1'b1;
              end
            end
          end else begin
            rresp_n = SLVERR;
          end
        end
      end
      R_DATA: begin
        if (axil_rvalid && axil_rready) begin
          r_state_n = R_ADDR;
          rvalid_n  = 1'b0;
          arready_n = 1'b1;
        end
      end
      default: r_state_n = R_ADDR;
    endcase
  end

  always_ff @(posedge axil_clk or posedge axil_rst) begin
    if (axil_rst) begin
      w_state_q     <= W_ADDR_DATA;
      r_state_q     <= R_ADDR;
      aw_held_q     <= 1'b0;
      w_held_q      <= 1'b0;
      aw_idx_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      ctrl_q        <= {N_CTRL{CTRL_RESET}};
      axil_awready  <= 1'b0;
      axil_wready   <= 1'b0;
      axil_bvalid   <= 1'b0;
      axil_bresp    <= 2'b00;
      axil_arready  <= 1'b0;
      axil_rvalid   <= 1'b0;
      axil_rresp    <= 2'b00;
      axil_rdata    <= '0;
      ctrl_wr_pulse <= '0;
      stat_rd_pulse <= '0;
    end else begin
      w_state_q     <= w_state_n;
      r_state_q     <= r_state_n;
      aw_held_q     <= aw_held_n;
      w_held_q      <= w_held_n;
      aw_idx_q      <= aw_idx_n;
      wdata_q       <= wdata_n;
      wstrb_q       <= wstrb_n;
      ctrl_q        <= ctrl_n;
      axil_awready  <= awready_n;
      axil_wready   <= wready_n;
      axil_bvalid   <= bvalid_n;
      axil_bresp    <= bresp_n;
      axil_arready  <= arready_n;
      axil_rvalid   <= rvalid_n;
      axil_rresp    <= rresp_n;
      axil_rdata    <= rdata_n;
      ctrl_wr_pulse <= wr_pulse_n;
      stat_rd_pulse <= rd_pulse_n;
    end
  end

endmodule
